// File: rtl/logicnet_input_packer_pkg.sv
// Shared types and default thresholds for the LogicNet input packer.
// Each feature quantizes against three thresholds into a 2-bit code.
package logicnet_input_pkg;

   localparam int IN_WIDTH             = 16;
   localparam int BW                   = 2;
   localparam int NUM_FEATURES_DEFAULT = 8;

   typedef logic [BW-1:0]                code_t;
   typedef logic signed [IN_WIDTH-1:0]   sample_t;

   localparam sample_t THRESH_DEFAULT [NUM_FEATURES_DEFAULT][3] = '{
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100},
      '{-16'sd100, 16'sd0, 16'sd100}
   };

   // Wraps the feature index so wider instances reuse the default table.
   function automatic sample_t thresh_default(input int f, input int k);
      return THRESH_DEFAULT[f % NUM_FEATURES_DEFAULT][k];
   endfunction

endpackage

// File: rtl/logicnet_input_packer_quantizer.sv
// feature_quantizer: counts how many of three thresholds a signed sample
// reaches (>=) and returns that count as a 2-bit code.
module feature_quantizer
   import logicnet_input_pkg::*;
(
   input  sample_t i_data,
   input  sample_t i_t0,
   input  sample_t i_t1,
   input  sample_t i_t2,
   output code_t   o_code
);

   // Threshold count; each compare contributes one.
   always_comb begin
      o_code = 2'd0;
      o_code = 2'(i_data >= i_t0) + 2'(i_data >= i_t1) + 2'(i_data >= i_t2);
   end

endmodule

// File: rtl/logicnet_input_packer.sv
// logicnet_input_packer: quantizes a stream of signed features and packs one frame
// into a held output vector. Define LOGICNET_THRESH_WR_EN for writable thresholds.
module logicnet_input_packer
   import logicnet_input_pkg::*;
#(
   parameter int NUM_FEATURES = NUM_FEATURES_DEFAULT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic signed [IN_WIDTH-1:0]        s_data,
   input  logic                              s_last,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [NUM_FEATURES*BW-1:0]        m_data,
   output logic                              err_frame,
   output logic [15:0]                       frame_cnt
`ifdef LOGICNET_THRESH_WR_EN
   ,
   input  logic                              cfg_we,
   input  logic [$clog2(3*NUM_FEATURES)-1:0] cfg_addr,
   input  logic [IN_WIDTH-1:0]               cfg_data
`endif
);

   localparam int IDX_W = $clog2(NUM_FEATURES);
   localparam int TW    = $clog2(3*NUM_FEATURES);
   localparam int VW    = NUM_FEATURES*BW;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES-1);

   logic [IDX_W-1:0] r_idx;
   logic [VW-1:0]    r_work;
   logic [VW-1:0]    r_m_data;
   logic             r_m_valid;
   logic             r_err_frame;
   logic [15:0]      r_frame_cnt;

   sample_t          w_thresh [3*NUM_FEATURES];
   sample_t          w_t0, w_t1, w_t2;
   logic [TW-1:0]    w_base;
   code_t            w_code;
   logic             w_at_last, w_accept, w_final, w_err;

`ifdef LOGICNET_THRESH_WR_EN
   sample_t r_thresh [3*NUM_FEATURES];

   // Threshold table; a beat in the same cycle as a write still sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 3*NUM_FEATURES; j++)
            r_thresh[j] <= thresh_default(j/3, j%3);
      end else if (cfg_we && (int'(cfg_addr) < 3*NUM_FEATURES)) begin
         r_thresh[cfg_addr] <= sample_t'(cfg_data);
      end
   end

   assign w_thresh = r_thresh;
`else
   for (genvar j = 0; j < 3*NUM_FEATURES; j++) begin : g_thresh
      assign w_thresh[j] = thresh_default(j/3, j%3);
   end
`endif

   // Select the three thresholds belonging to the feature being collected.
   always_comb begin
      w_base = TW'(32'd3 * 32'(r_idx));
      w_t0   = w_thresh[w_base];
      w_t1   = w_thresh[w_base + TW'(1)];
      w_t2   = w_thresh[w_base + TW'(2)];
   end

   feature_quantizer u_quant (
      .i_data (s_data),
      .i_t0   (w_t0),
      .i_t1   (w_t1),
      .i_t2   (w_t2),
      .o_code (w_code)
   );

   // Only the final beat can stall, and only while the previous vector is still held.
   assign w_at_last = (r_idx == LAST_IDX);
   assign s_ready   = !(w_at_last && r_m_valid && !m_ready);
   assign w_accept  = s_valid && s_ready;
   assign w_final   = w_accept && w_at_last && s_last;
   assign w_err     = w_accept && (w_at_last != s_last);

   // Frame collection, output hold register and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_work      <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_err_frame <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_err_frame <= w_err;
         if (w_final) begin
            r_m_data    <= {w_code, r_work[VW-BW-1:0]};
            r_m_valid   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end else if (r_m_valid && m_ready) begin
            r_m_valid   <= 1'b0;
         end
         if (w_final || w_err) begin
            r_idx  <= '0;
            r_work <= '0;
         end else if (w_accept) begin
            r_idx                        <= r_idx + IDX_W'(1);
            r_work[32'(r_idx)*BW +: BW]  <= w_code;
         end
      end
   end

   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign err_frame = r_err_frame;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed self-checking bench for logicnet_input_packer (8 features, 2-bit codes).
module tb_logicnet_input_packer;

   typedef logic signed [15:0] frame_t [8];

   logic               clk = 1'b0;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic signed [15:0] s_data;
   logic               s_last;
   logic               m_valid;
   logic               m_ready;
   logic [15:0]        m_data;
   logic               err_frame;
   logic [15:0]        frame_cnt;
`ifdef LOGICNET_THRESH_WR_EN
   logic               cfg_we;
   logic [4:0]         cfg_addr;
   logic [15:0]        cfg_data;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0;
   frame_t fa, fb;

   logicnet_input_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .err_frame (err_frame),
      .frame_cnt (frame_cnt)
`ifdef LOGICNET_THRESH_WR_EN
      ,
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one beat at posedge+1 and return at posedge+1 after it is taken.
   task automatic beat(input logic signed [15:0] d, input logic l);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      n = 0;
      while (!s_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("beat_accept", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input frame_t f);
      for (int i = 0; i < 8; i++) beat(f[i], (i == 7));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Defaults -100/0/100: codes f0..f7 = 00,01,10,11,11,10,01,00 -> 16'h1BE4
      fa = '{-16'sd200, -16'sd50, 16'sd0, 16'sd150, 16'sd100, 16'sd99, -16'sd100, -16'sd101};
      // codes f0..f7 = 11,01,10,01,10,11,00,11 -> 16'hCE67
      fb = '{16'sd100, -16'sd100, 16'sd0, -16'sd1, 16'sd99, 16'sd101, -16'sd101, 16'sd32767};

      rst_n = 1'b0; s_valid = 1'b0; s_data = 16'sd0; s_last = 1'b0; m_ready = 1'b1;
`ifdef LOGICNET_THRESH_WR_EN
      cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 16'd0;
`endif
      #12;
      chk("rst_s_ready",   32'(s_ready),   32'd1);
      chk("rst_m_valid",   32'(m_valid),   32'd0);
      chk("rst_m_data",    32'(m_data),    32'd0);
      chk("rst_err_frame", 32'(err_frame), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame, sink always ready
      send_frame(fa);
      chk("f1_m_valid", 32'(m_valid),   32'd1);
      chk("f1_m_data",  32'(m_data),    32'h1BE4);
      chk("f1_cnt",     32'(frame_cnt), 32'd1);
      @(posedge clk); #1;
      chk("f1_consumed", 32'(m_valid), 32'd0);

      // Held output while next frame collects; final beat stalls
      m_ready = 1'b0;
      send_frame(fa);
      chk("h1_m_valid", 32'(m_valid),   32'd1);
      chk("h1_cnt",     32'(frame_cnt), 32'd2);
      for (int i = 0; i < 7; i++) beat(fb[i], 1'b0);
      chk("h1_data_mid", 32'(m_data), 32'h1BE4);
      s_valid = 1'b1; s_data = fb[7]; s_last = 1'b1;
      chk("h2_stall", 32'(s_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("h2_stall_hold", 32'(s_ready),   32'd0);
      chk("h1_data_hold",  32'(m_data),    32'h1BE4);
      chk("h1_valid_hold", 32'(m_valid),   32'd1);
      chk("h_cnt_hold",    32'(frame_cnt), 32'd2);
      m_ready = 1'b1;
      #1;
      chk("h2_ready_comb", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      chk("h2_m_valid", 32'(m_valid),   32'd1);
      chk("h2_m_data",  32'(m_data),    32'hCE67);
      chk("h2_cnt",     32'(frame_cnt), 32'd3);
      @(posedge clk); #1;
      chk("h2_consumed", 32'(m_valid), 32'd0);

      // Early s_last
      beat(fa[0], 1'b0); beat(fa[1], 1'b0); beat(fa[2], 1'b1);
      chk("e1_err",     32'(err_frame), 32'd1);
      chk("e1_m_valid", 32'(m_valid),   32'd0);
      @(posedge clk); #1;
      chk("e1_err_pulse", 32'(err_frame), 32'd0);
      send_frame(fa);
      chk("e1_next_data", 32'(m_data),    32'h1BE4);
      chk("e1_next_cnt",  32'(frame_cnt), 32'd4);
      // Missing s_last on the final feature
      for (int i = 0; i < 8; i++) beat(fb[i], 1'b0);
      chk("e2_err",     32'(err_frame), 32'd1);
      chk("e2_m_valid", 32'(m_valid),   32'd0);
      chk("e2_cnt",     32'(frame_cnt), 32'd4);
      @(posedge clk); #1;
      chk("e2_err_pulse", 32'(err_frame), 32'd0);
      send_frame(fb);
      chk("e2_next_data", 32'(m_data),    32'hCE67);
      chk("e2_next_cnt",  32'(frame_cnt), 32'd5);
      @(posedge clk); #1;

      // Reset with a held vector and a partial frame in flight
      m_ready = 1'b0;
      send_frame(fa);
      chk("r_m_valid_pre", 32'(m_valid), 32'd1);
      for (int i = 0; i < 5; i++) beat(fb[i], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("r_m_valid",   32'(m_valid),   32'd0);
      chk("r_m_data",    32'(m_data),    32'd0);
      chk("r_cnt",       32'(frame_cnt), 32'd0);
      chk("r_s_ready",   32'(s_ready),   32'd1);
      chk("r_err_frame", 32'(err_frame), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b1;
      send_frame(fb);
      chk("r_next_data", 32'(m_data),    32'hCE67);
      chk("r_next_cnt",  32'(frame_cnt), 32'd1);
      @(posedge clk); #1;

      // Back-to-back frames across the counter wrap
      force dut.r_frame_cnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      chk("w_preset", 32'(frame_cnt), 32'hFFFF);
      send_frame(fa);
      t0 = cyc;
      chk("w_wrap_cnt",  32'(frame_cnt), 32'd0);
      chk("w_wrap_data", 32'(m_data),    32'h1BE4);
      send_frame(fb);
      chk("w_b2b_cnt",   32'(frame_cnt), 32'd1);
      chk("w_b2b_data",  32'(m_data),    32'hCE67);
      chk("w_b2b_valid", 32'(m_valid),   32'd1);
      chk("w_b2b_cycles", 32'(cyc - t0), 32'd8);
      @(posedge clk); #1;

`ifdef LOGICNET_THRESH_WR_EN
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Write feature-0 t1=500 alongside beat 50: old thresholds give 10 -> 16'hAAAA
      cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 16'd500;
      beat(16'sd50, 1'b0);
      cfg_we = 1'b0;
      for (int i = 1; i < 7; i++) beat(16'sd0, 1'b0);
      beat(16'sd0, 1'b1);
      chk("c_same_cycle", 32'(m_data), 32'hAAAA);
      cfg_we = 1'b1; cfg_addr = 5'd2; cfg_data = 16'd1000;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      // 200 vs {-100, 500, 1000} -> 01, others stay 10 -> 16'hAAA9
      beat(16'sd200, 1'b0);
      for (int i = 1; i < 7; i++) beat(16'sd0, 1'b0);
      beat(16'sd0, 1'b1);
      chk("c_new_thresh", 32'(m_data), 32'hAAA9);
      @(posedge clk); #1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
